// File: rtl/apb_bridge.sv
// Bridges one core bus request into one APB3 transfer on a slave decoded from bus_addr[SEL_LSB +: IDX_W].
// Optional feature macro APB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYCLES cycles with bus_err.
module apb_bridge #(
  parameter int NUM_SLV        = 4,
  parameter int SEL_LSB        = 12,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wdata,
  input  logic                  bus_write,
  input  logic                  bus_valid,
  output logic [31:0]           bus_rdata,
  output logic                  bus_ready,
  output logic                  bus_err,
  output logic [ADDR_W-1:0]     paddr,
  output logic [NUM_SLV-1:0]    psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  input  logic [NUM_SLV*32-1:0] prdata,
  input  logic [NUM_SLV-1:0]    pready,
  input  logic [NUM_SLV-1:0]    pslverr
);
  localparam int IDX_W = $clog2(NUM_SLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [31:0]         bus_rdata_q, bus_rdata_d;
  logic                bus_ready_q, bus_ready_d;
  logic                bus_err_q, bus_err_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d;

  logic [IDX_W-1:0]    req_idx;
  logic                sel_ready, sel_err;
  logic [31:0]         sel_rdata;
  logic                tmo_hit;
  logic                unused_addr_bits;

  assign req_idx          = bus_addr[SEL_LSB +: IDX_W];
  assign unused_addr_bits = ^bus_addr;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // psel_q is one-hot during ACCESS, so it doubles as the response mux select.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_rdata_d = bus_rdata_q;
    bus_ready_d = 1'b0;
    bus_err_d   = bus_err_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
`ifdef APB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_valid) begin
          paddr_d   = bus_addr[ADDR_W-1:0];
          pwdata_d  = bus_wdata;
          pwrite_d  = bus_write;
          bus_err_d = 1'b0;
          if (32'(req_idx) < NUM_SLV) begin
            psel_d  = NUM_SLV'(1) << req_idx;
            state_d = SETUP;
          end else begin
            bus_err_d   = 1'b1;
            bus_rdata_d = '0;
            bus_ready_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready || tmo_hit) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          bus_ready_d = 1'b1;
          state_d     = RESP;
          // A pready in the timeout cycle takes priority over the abort.
          bus_err_d   = sel_ready ? sel_err : 1'b1;
          bus_rdata_d = (!sel_ready || sel_err || pwrite_q) ? 32'h0 : sel_rdata;
        end else begin
`ifdef APB_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_rdata_q <= '0;
      bus_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bus_rdata_q <= bus_rdata_d;
      bus_ready_q <= bus_ready_d;
      bus_err_q   <= bus_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign bus_ready = bus_ready_q;
  assign bus_err   = bus_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_bridge.sv
// Bench for apb_bridge: a 4-slave and a 3-slave instance driven from one request stream,
// with transfers predicted from bus-level rules (latency, select, data and error outcome).
module tb_apb_bridge;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  bus_addr, bus_wdata;
  logic         bus_write, bus_valid;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;
  bit           use3;

  logic         v4, v3;
  logic [31:0]  rdata4, rdata3, pwdata4, pwdata3;
  logic         ready4, ready3, err4, err3, pen4, pen3, pwr4, pwr3;
  logic [11:0]  paddr4, paddr3;
  logic [3:0]   psel4;
  logic [2:0]   psel3;

  logic [31:0]  o_rdata, o_pwdata;
  logic         o_ready, o_err, o_penable, o_pwrite;
  logic [11:0]  o_paddr;
  logic [3:0]   o_psel;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign v4 = bus_valid & ~use3;
  assign v3 = bus_valid & use3;

  apb_bridge #(.NUM_SLV(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
    .bus_valid(v4), .bus_rdata(rdata4), .bus_ready(ready4), .bus_err(err4),
    .paddr(paddr4), .psel(psel4), .penable(pen4), .pwrite(pwr4), .pwdata(pwdata4),
    .prdata(prdata), .pready(pready), .pslverr(pslverr));

  apb_bridge #(.NUM_SLV(3), .TIMEOUT_CYCLES(TMO)) dut3 (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
    .bus_valid(v3), .bus_rdata(rdata3), .bus_ready(ready3), .bus_err(err3),
    .paddr(paddr3), .psel(psel3), .penable(pen3), .pwrite(pwr3), .pwdata(pwdata3),
    .prdata(prdata[95:0]), .pready(pready[2:0]), .pslverr(pslverr[2:0]));

  always_comb begin
    if (use3) begin
      o_rdata = rdata3; o_ready = ready3; o_err = err3; o_paddr = paddr3;
      o_psel = {1'b0, psel3}; o_penable = pen3; o_pwrite = pwr3; o_pwdata = pwdata3;
    end else begin
      o_rdata = rdata4; o_ready = ready4; o_err = err4; o_paddr = paddr4;
      o_psel = psel4; o_penable = pen4; o_pwrite = pwr4; o_pwdata = pwdata4;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave side for cycle 'cyc' of a transfer: the addressed slave answers after 'waits'
  // ACCESS cycles; everything it is not supposed to look at is randomised.
  task automatic drive_slaves(input int idx, input int cyc, input int waits,
                              input logic serr, input logic [31:0] rdv);
    logic [3:0] rdy, err;
    rdy = 4'($urandom);
    err = 4'($urandom);
    for (int i = 0; i < 4; i++) prdata[32*i +: 32] = $urandom;
    if (cyc >= 2 + waits) rdy[idx] = 1'b1;
    else if (cyc >= 2) rdy[idx] = 1'b0;
    if (rdy[idx]) err[idx] = serr;
    prdata[32*idx +: 32] = rdv;
    pready  = rdy;
    pslverr = err;
  endtask

  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          input int waits, input logic serr, input logic [31:0] rdv);
    int         nslv, idx, rc;
    bit         good, tmo;
    logic       exp_err;
    logic [31:0] exp_rd;
    logic [3:0] exp_psel;
    nslv = use3 ? 3 : 4;
    idx  = int'(addr[13:12]);
    good = idx < nslv;
`ifdef APB_TIMEOUT_EN
    tmo = good && (waits >= TMO);
`else
    tmo = 1'b0;
`endif
    rc       = !good ? 1 : (tmo ? 2 + TMO : 3 + waits);
    exp_err  = !good || tmo || serr;
    exp_rd   = (exp_err || wr) ? 32'h0 : rdv;
    exp_psel = good ? 4'(1 << idx) : 4'h0;

    @(negedge clk);
    bus_addr = addr; bus_wdata = wdata; bus_write = wr; bus_valid = 1'b1;
    drive_slaves(idx, 0, waits, serr, rdv);
    for (int c = 1; c <= rc + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus_addr = $urandom; bus_wdata = $urandom; bus_write = 1'($urandom);
      end
      check("ready", o_ready, 64'(c == rc));
      if (good && c < rc)
        check("apb", {o_psel, o_penable, o_pwrite, o_paddr, o_pwdata},
              {exp_psel, (c >= 2), wr, addr[11:0], wdata});
      else
        check("apb_idle", {o_psel, o_penable}, 5'b0);
      if (c == rc) begin
        check("rdata", o_rdata, exp_rd);
        check("err", o_err, exp_err);
      end
      if (c == rc + 1) begin
        check("rdata_hold", o_rdata, exp_rd);
        bus_valid = 1'b0;
      end
      drive_slaves(idx, c, waits, serr, rdv);
    end
  endtask

  task automatic reset_and_check();
    @(negedge clk);
    rst = 1'b1; bus_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    use3 = 1'b0; #1;
    check("reset4", {o_ready, o_err, o_rdata, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata}, 64'h0);
    use3 = 1'b1; #1;
    check("reset3", {o_ready, o_err, o_rdata, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata}, 64'h0);
    use3 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (limit 2000000 required)");
    $fatal(1);
  end

  initial begin
    int rdy_cnt;
    rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_write = 1'b0; bus_valid = 1'b0;
    prdata = '0; pready = '0; pslverr = '0; use3 = 1'b0;
    reset_and_check();

    run_xfer(32'h8000_1004, 32'h5555_AAAA, 1'b0, 0, 1'b0, 32'hCAFE_0001);
    run_xfer(32'h8000_2010, 32'h1234_5678, 1'b1, 3, 1'b0, 32'hDEAD_BEEF);
    run_xfer(32'h8000_0020, 32'h0,         1'b0, 1, 1'b1, 32'h7777_7777);
    use3 = 1'b1;
    run_xfer(32'h8000_3000, 32'h0,         1'b0, 0, 1'b0, 32'h1111_2222);
    run_xfer(32'h8000_2008, 32'h0,         1'b0, 2, 1'b0, 32'h3333_4444);
    use3 = 1'b0;

    // Reset during ACCESS, then a normal read.
    @(negedge clk);
    bus_addr = 32'h8000_2040; bus_write = 1'b0; bus_valid = 1'b1;
    drive_slaves(2, 0, 1000, 1'b0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      drive_slaves(2, c, 1000, 1'b0, 32'h0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", {o_psel, o_penable, o_ready}, 6'b0);
    rst = 1'b0; bus_valid = 1'b0;
    run_xfer(32'h8000_3ABC, 32'h0, 1'b0, 1, 1'b0, 32'h0BAD_F00D);

    // Addressed slave never answers.
`ifdef APB_TIMEOUT_EN
    run_xfer(32'h8000_1100, 32'h0, 1'b0, 5000, 1'b0, 32'h9999_9999);
    run_xfer(32'h8000_1104, 32'h0, 1'b0, TMO - 1, 1'b0, 32'h8888_8888);
`else
    @(negedge clk);
    bus_addr = 32'h8000_1100; bus_write = 1'b0; bus_valid = 1'b1;
    rdy_cnt = 0;
    drive_slaves(1, 0, 5000, 1'b0, 32'h0);
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      if (o_ready) rdy_cnt++;
      drive_slaves(1, c, 5000, 1'b0, 32'h0);
    end
    check("stuck_no_ready", 64'(rdy_cnt), 64'h0);
    check("stuck_psel", o_psel, 4'b0010);
    reset_and_check();
`endif

    for (int n = 0; n < 60; n++) begin
      use3 = ($urandom_range(0, 3) == 0);
      run_xfer($urandom | 32'h8000_0000, $urandom, 1'($urandom), $urandom_range(0, 5),
               ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
